// File: rtl/pcie_dma_pkg.sv
// pcie_dma: shared descriptor layout, FSM encodings and default sizing
// for the PCIe completion scheduler.  Rev 1.0
`default_nettype none

package pcie_dma;

  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_TIMEOUT = 1023;

  localparam int DESC_W = 64;
  localparam int TMO_W  = 11;
  localparam int CNT_W  = 16;

  // Field widths; offsets follow from the packed order below (addr at bit 0).
  localparam int ADDR_W = 13;
  localparam int BE_W   = 8;
  localparam int TAG_W  = 8;
  localparam int RID_W  = 16;
  localparam int LEN_W  = 10;
  localparam int ATTR_W = 2;
  localparam int TC_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DMA_REQ  = 2'd1,
    ST_DMA_WAIT = 2'd2,
    ST_CPL_WAIT = 2'd3
  } state_t;

  typedef struct packed {
    logic              rsvd;
    logic              wd;
    logic [TC_W-1:0]   tc;
    logic              td;
    logic              ep;
    logic [ATTR_W-1:0] attr;
    logic [LEN_W-1:0]  len;
    logic [RID_W-1:0]  rid;
    logic [TAG_W-1:0]  tag;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
  } desc_t;

  // DMA reads are issued on 8-byte boundaries.
  function automatic logic [ADDR_W-1:0] dma_addr(input desc_t d);
    return {d.addr[ADDR_W-1:3], 3'b000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pcie_cpl_queue.sv
// pcie_cpl_queue: DEPTH-entry descriptor FIFO, no bypass; a full queue
// refuses pushes even when popped in the same cycle.  Rev 1.0
`default_nettype none

module pcie_cpl_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_empty = (count_q == '0);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q is non-zero.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_push_data;
  end

endmodule

`default_nettype wire

// File: rtl/pcie_cpl_scheduler.sv
// pcie_cpl_scheduler: queues completion requests, fetches payload via DMA,
// and hands one descriptor at a time to the TX engine.  Rev 1.0
`default_nettype none

module pcie_cpl_scheduler
  import pcie_dma::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [DESC_W-1:0] i_req_desc,
  output logic              o_dma_req_valid,
  input  logic              i_dma_req_ready,
  output logic [ADDR_W-1:0] o_dma_req_addr,
  input  logic              i_dma_resp_valid,
  input  logic              i_dma_resp_fault,
  output logic              o_req_compl,
  output logic [DESC_W-1:0] o_cpl_desc,
  input  logic              i_compl_done,
  output logic              o_busy,
  output logic              o_timeout,
  output logic              o_fault,
  output logic [CNT_W-1:0]  o_cpl_cnt
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  desc_t             cur_q, cur_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [CNT_W-1:0]  cpl_cnt_q, cpl_cnt_d;
  logic              fault_q, fault_d;
  logic              timeout_q, timeout_d;

  logic              q_pop;
  logic [DESC_W-1:0] q_head;
  logic              q_full;
  logic              q_empty;

  pcie_cpl_queue #(
    .DEPTH (DEPTH),
    .WIDTH (DESC_W)
  ) u_queue (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .i_push      (i_req_valid),
    .i_push_data (i_req_desc),
    .i_pop       (q_pop),
    .o_head      (q_head),
    .o_full      (q_full),
    .o_empty     (q_empty)
  );

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    tmo_d     = tmo_q;
    cpl_cnt_d = cpl_cnt_q;
    fault_d   = fault_q;
    timeout_d = 1'b0;
    q_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!q_empty) begin
          cur_d   = desc_t'(q_head);
          q_pop   = 1'b1;
          state_d = ST_DMA_REQ;
        end
      end
      ST_DMA_REQ: begin
        if (i_dma_req_ready) begin
          tmo_d   = '0;
          state_d = ST_DMA_WAIT;
        end
      end
      ST_DMA_WAIT: begin
        if (i_dma_resp_valid) begin
          if (i_dma_resp_fault) fault_d = 1'b1;
          state_d = ST_CPL_WAIT;
        end else begin
          tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
          // The counter reaches TIMEOUT on this edge: drop the request.
          if (tmo_q >= TMO_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_CPL_WAIT: begin
        if (i_compl_done) begin
          cpl_cnt_d = cpl_cnt_q + CNT_W'(1);
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      tmo_q     <= '0;
      cpl_cnt_q <= '0;
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      tmo_q     <= tmo_d;
      cpl_cnt_q <= cpl_cnt_d;
      fault_q   <= fault_d;
      timeout_q <= timeout_d;
    end
  end

  // TX-facing outputs depend only on registers so the TX engine sees a
  // stable descriptor in the cycle the DMA response arrives.
  assign o_req_ready     = !q_full;
  assign o_dma_req_valid = (state_q == ST_DMA_REQ);
  assign o_dma_req_addr  = dma_addr(cur_q);
  assign o_req_compl     = (state_q == ST_DMA_WAIT) || (state_q == ST_CPL_WAIT);
  assign o_cpl_desc      = o_req_compl ? DESC_W'(cur_q) : '0;
  assign o_busy          = (state_q != ST_IDLE) || !q_empty;
  assign o_timeout       = timeout_q;
  assign o_fault         = fault_q;
  assign o_cpl_cnt       = cpl_cnt_q;

endmodule

`default_nettype wire
